// File: rtl/banzai_pkg.sv
// Shared definitions for the banzai result path: register map, STATUS layout,
// AXI response codes, read-beat payload and small decode/pack helpers.
package banzai_pkg;

    localparam int unsigned AXI_DATA_W = 32;

    localparam logic [7:0] REG_DATA_OFF   = 8'h00;
    localparam logic [7:0] REG_STATUS_OFF = 8'h04;
    localparam logic [7:0] REG_CTRL_OFF   = 8'h08;

    localparam int unsigned STATUS_COUNT_W   = 9;
    localparam int unsigned STATUS_EMPTY_BIT = 16;
    localparam int unsigned STATUS_FULL_BIT  = 17;
    localparam int unsigned STATUS_OVF_BIT   = 24;

    localparam int unsigned CTRL_FLUSH_BIT   = 0;
    localparam int unsigned CTRL_CLR_OVF_BIT = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        SEL_DATA,
        SEL_STATUS,
        SEL_CTRL,
        SEL_NONE
    } reg_sel_e;

    // One R-channel beat as held in the response register.
    typedef struct packed {
        logic [1:0]            resp;
        logic [AXI_DATA_W-1:0] data;
    } r_beat_t;

    // Map the low address byte onto a register select.
    function automatic reg_sel_e decode_offset(input logic [7:0] off);
        reg_sel_e sel;
        case (off)
            REG_DATA_OFF:   sel = SEL_DATA;
            REG_STATUS_OFF: sel = SEL_STATUS;
            REG_CTRL_OFF:   sel = SEL_CTRL;
            default:        sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    // Assemble the STATUS word; unlisted bits read as zero.
    function automatic logic [AXI_DATA_W-1:0] pack_status(
        input logic [STATUS_COUNT_W-1:0] count,
        input logic                      empty,
        input logic                      full,
        input logic                      ovf
    );
        logic [AXI_DATA_W-1:0] s;
        s                   = '0;
        s[STATUS_COUNT_W-1:0] = count;
        s[STATUS_EMPTY_BIT] = empty;
        s[STATUS_FULL_BIT]  = full;
        s[STATUS_OVF_BIT]   = ovf;
        return s;
    endfunction

endpackage

// File: rtl/banzai_sync_fifo.sv
// Single-clock FIFO with push/pop/flush.
// Ports: clk, rst_n (async active-low); push/push_data write the tail, pop
// advances the head, flush empties; head_c is the current head word,
// full_c/empty_c decode the count register, count and nonempty are registered.
// Push is ignored when full and pop when empty, both judged on pre-cycle state.
// Flush is applied after a same-cycle pop, so head_c is still valid that cycle.
module banzai_sync_fifo #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_c,
    output logic             full_c,
    output logic             empty_c,
    output logic [CNT_W-1:0] count,
    output logic             nonempty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;
    logic [CNT_W-1:0] count_n_c;

    // Qualify requests and form the next count.
    always_comb begin
        full_c    = (count == CNT_W'(DEPTH));
        empty_c   = (count == '0);
        head_c    = mem[rd_ptr];
        do_push_c = push & ~full_c;
        do_pop_c  = pop & ~empty_c;
        count_n_c = count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end

    // Storage has no reset.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            nonempty <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            nonempty <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + PTR_W'(do_push_c);
            rd_ptr   <= rd_ptr + PTR_W'(do_pop_c);
            count    <= count_n_c;
            nonempty <= (count_n_c != '0);
        end
    end

endmodule

// File: rtl/banzai_result_fifo.sv
// AXI-Lite slave that buffers banzai accelerator results for CPU readout.
// Ports: clk_i/rst_ni; AXI-Lite AW/W/B and AR/R channels; irq_o is high while
// the FIFO holds data. Registers: 0x00 DATA (write pushes, read pops),
// 0x04 STATUS (read only), 0x08 CTRL (write only: bit0 flush, bit1 clear
// overflow). Any other access answers SLVERR without side effects.
module banzai_result_fifo
    import banzai_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [31:0]             awaddr_i,
    input  logic [2:0]              awprot_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [3:0]              wstrb_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic [31:0]             araddr_i,
    input  logic [2:0]              arprot_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic                    irq_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic             aw_ready_q;
    logic             ar_ready_q;
    logic             b_valid_q;
    logic [1:0]       b_resp_q;
    logic             r_valid_q;
    r_beat_t          r_q;
    logic             overflow_q;

    logic             wr_acc_c;
    logic             rd_acc_c;
    reg_sel_e         wr_sel_c;
    reg_sel_e         rd_sel_c;
    logic             push_c;
    logic             pop_c;
    logic             flush_c;
    logic             set_ovf_c;
    logic             clr_ovf_c;
    logic [1:0]       b_resp_n_c;
    r_beat_t          r_n_c;

    logic [DATA_WIDTH-1:0] fifo_head_c;
    logic                  fifo_full_c;
    logic                  fifo_empty_c;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_nonempty;

    // Protection and upper address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{awprot_i, arprot_i, awaddr_i[31:8], araddr_i[31:8]};

    banzai_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (push_c),
        .push_data (wdata_i),
        .pop       (pop_c),
        .flush     (flush_c),
        .head_c    (fifo_head_c),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c),
        .count     (fifo_count),
        .nonempty  (fifo_nonempty)
    );

    // Decode accepted transactions against pre-cycle FIFO state.
    always_comb begin
        push_c     = 1'b0;
        pop_c      = 1'b0;
        flush_c    = 1'b0;
        set_ovf_c  = 1'b0;
        clr_ovf_c  = 1'b0;
        b_resp_n_c = RESP_SLVERR;
        r_n_c      = '{resp: RESP_SLVERR, data: '0};

        wr_acc_c = aw_ready_q & awvalid_i & wvalid_i;
        rd_acc_c = ar_ready_q & arvalid_i;
        wr_sel_c = decode_offset(awaddr_i[7:0]);
        rd_sel_c = decode_offset(araddr_i[7:0]);

        case (wr_sel_c)
            SEL_DATA: begin
                if (fifo_full_c) begin
                    set_ovf_c = wr_acc_c;
                end else if (wstrb_i == 4'hF) begin
                    push_c     = wr_acc_c;
                    b_resp_n_c = RESP_OKAY;
                end
            end
            SEL_CTRL: begin
                flush_c    = wr_acc_c & wdata_i[CTRL_FLUSH_BIT];
                clr_ovf_c  = wr_acc_c & wdata_i[CTRL_CLR_OVF_BIT];
                b_resp_n_c = RESP_OKAY;
            end
            default: ;
        endcase

        case (rd_sel_c)
            SEL_DATA: begin
                if (!fifo_empty_c) begin
                    pop_c = rd_acc_c;
                    r_n_c = '{resp: RESP_OKAY, data: fifo_head_c};
                end
            end
            SEL_STATUS: begin
                r_n_c = '{resp: RESP_OKAY,
                          data: pack_status(STATUS_COUNT_W'(fifo_count), fifo_empty_c,
                                            fifo_full_c, overflow_q)};
            end
            default: ;
        endcase
    end

    // Handshake and response registers; ready is a one-cycle pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_ready_q <= 1'b0;
            ar_ready_q <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= '0;
            r_valid_q  <= 1'b0;
            r_q        <= '0;
            overflow_q <= 1'b0;
        end else begin
            aw_ready_q <= awvalid_i & wvalid_i & ~b_valid_q & ~aw_ready_q;
            ar_ready_q <= arvalid_i & ~r_valid_q & ~ar_ready_q;

            if (wr_acc_c) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= b_resp_n_c;
            end else if (bready_i) begin
                b_valid_q <= 1'b0;
            end

            if (rd_acc_c) begin
                r_valid_q <= 1'b1;
                r_q       <= r_n_c;
            end else if (rready_i) begin
                r_valid_q <= 1'b0;
            end

            if (set_ovf_c) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf_c) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign awready_o = aw_ready_q;
    assign wready_o  = aw_ready_q;
    assign bvalid_o  = b_valid_q;
    assign bresp_o   = b_resp_q;
    assign arready_o = ar_ready_q;
    assign rvalid_o  = r_valid_q;
    assign rresp_o   = r_q.resp;
    assign rdata_o   = r_q.data;
    assign irq_o     = fifo_nonempty;

endmodule
